cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//  Multicycle control FSM for the single-issue ARM-subset CPU. Steps each instruction through
//  FETCH/DECODE/EXEC/MEM/WB and evaluates ARM condition codes against NZCV. Drives PC update
//  (pc_we_o/pc_sel_o into fetch), register-file writes, flag writes and the data-memory
//  req/ack handshake. Sits beside fetch and owns the instruction register.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in MEM waiting for mem_ack_i before fault_o; range 1..255
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   asynchronous, active-high reset
//  inst_i      in   32  instruction from code memory, valid in FETCH
//  flags_i     in   4   current {N,Z,C,V}
//  mem_ack_i   in   1   data memory completes the access this cycle
//  ir_o        out  32  latched instruction register
//  state_o     out  3   FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
//  pc_we_o     out  1   fetch updates PC this cycle
//  pc_sel_o    out  2   0=PC+4, 1=branch target (PC+8+simm24<<2), 2=writeback data
//  reg_we_o    out  1   register-file write strobe
//  reg_wa_o    out  4   write address: ir[15:12], or 14 for BL link
//  wb_sel_o    out  2   0=ALU result, 1=load data, 2=link (PC+4)
//  flags_we_o  out  1   latch ALU NZCV into flags
//  mem_req_o   out  1   data-memory request, held until ack
//  mem_we_o    out  1   1=store, 0=load; valid while mem_req_o=1
//  fault_o     out  1   sticky memory-timeout fault
// BEHAVIOUR
//  - Reset (async): state=FETCH, ir_r=0, cond_r=0, wait counter=0, fault_o=0. All strobes 0.
//    Reset during MEM drops mem_req_o immediately; the access is abandoned.
//  - Strobes are combinational from state_r, ir_r, cond_r and mem_ack_i; each is 1 cycle unless stated.
//  - FETCH: ir_r<=inst_i at clock edge -> DECODE.
//  - DECODE: cond_r<=eval(ir[31:28], flags_i) -> EXEC. Codes: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N;
//    VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 never.
//  - EXEC, cond_r=0: pc_we_o=1, pc_sel_o=0 -> FETCH. No other strobe (squashed).
//  - EXEC, branch (ir[27:25]=101): pc_we_o=1, pc_sel_o=1; if ir[24] (BL) also reg_we_o=1,
//    reg_wa_o=14, wb_sel_o=2. -> FETCH.
//  - EXEC, data-proc (ir[27:26]=00): flags_we_o=ir[20] -> WB.
//  - EXEC, load/store (ir[27:26]=01): -> MEM; clear wait counter.
//  - EXEC, other encodings: treated as squashed (PC+4) -> FETCH.
//  - MEM: mem_req_o=1, mem_we_o=!ir[20]. Counter increments each cycle without ack.
//    ack: store -> pc_we_o=1, pc_sel_o=0, FETCH; load -> WB.
//    Counter reaches MEM_TIMEOUT without ack: fault_o<=1, pc_we_o=1, pc_sel_o=0, FETCH.
//    Ack in the same cycle as the timeout: ack wins, no fault.
//  - WB: reg_we_o=1, reg_wa_o=ir[15:12], wb_sel_o=(load?1:0), except TST/TEQ/CMP/CMN
//    (ir[24:23]=10, data-proc), which do not write. If a write targets r15: pc_sel_o=2,
//    else pc_sel_o=0; pc_we_o=1. -> FETCH.
//  - Exactly one pc_we_o pulse per instruction. fault_o clears only on reset.
//  - Latency in cycles: squashed 3, branch 3, data-proc 4, store 4+wait, load 5+wait.
// TESTING
//  - Reset mid-MEM (req high) -> mem_req_o=0 same cycle, state_o=0; fault_o=0 after release.
//  - ADD r1 (E0811002), flags 0000 -> states 0,1,2,4; reg_we_o in WB with wa=1, sel=0;
//    pc_sel_o=0; total 4 cycles.
//  - BEQ with Z=0 then Z=1 -> Z=0: pc_sel_o=0 in EXEC. Z=1: pc_sel_o=1.
//    BL (EB000004) -> reg_wa_o=14, wb_sel_o=2.
//  - LDR r15 (E59FF000), ack after 3 cycles -> mem_req_o high 3 cycles, mem_we_o=0;
//    WB has pc_sel_o=2, reg_wa_o=15.
//  - STR, no ack, MEM_TIMEOUT=4 -> fault_o=1 after 4 MEM cycles, pc_sel_o=0, FETCH.
//    Ack on the 4th cycle instead -> no fault.
//  - CMP (E1510002, S=1) -> flags_we_o in EXEC; no reg_we_o in WB; one pc_we_o pulse.

Source files
------------

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multicycle control FSM for the ARM-subset CPU
//
// Purpose:
//   Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, evaluates the
//   ARM condition field against NZCV, owns the instruction register and
//   drives PC update, register-file write, flag write and the data-memory
//   request/acknowledge handshake.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   reset       in   1   asynchronous active-high reset
//   inst_i      in   32  instruction from code memory, sampled in FETCH
//   flags_i     in   4   current {N,Z,C,V}, sampled in DECODE
//   mem_ack_i   in   1   data memory completes the access this cycle
//   ir_o        out  32  latched instruction register
//   state_o     out  3   FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
//   pc_we_o     out  1   fetch updates PC this cycle
//   pc_sel_o    out  2   0=PC+4, 1=branch target, 2=writeback data
//   reg_we_o    out  1   register-file write strobe
//   reg_wa_o    out  4   register-file write address
//   wb_sel_o    out  2   0=ALU result, 1=load data, 2=link (PC+4)
//   flags_we_o  out  1   latch ALU NZCV into flags
//   mem_req_o   out  1   data-memory request, held until ack
//   mem_we_o    out  1   1=store, 0=load; valid while mem_req_o=1
//   fault_o     out  1   sticky memory-timeout fault

module cpu_sequencer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] inst_i,
   input  logic [3:0]  flags_i,
   input  logic        mem_ack_i,
   output logic [31:0] ir_o,
   output logic [2:0]  state_o,
   output logic        pc_we_o,
   output logic [1:0]  pc_sel_o,
   output logic        reg_we_o,
   output logic [3:0]  reg_wa_o,
   output logic [1:0]  wb_sel_o,
   output logic        flags_we_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic        fault_o
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
   localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
   localparam logic [1:0] PC_SEL_WB     = 2'd2;

   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_LOAD = 2'd1;
   localparam logic [1:0] WB_SEL_LINK = 2'd2;

   localparam logic [3:0] LINK_REG = 4'd14;
   localparam logic [3:0] PC_REG   = 4'd15;

   // The counter holds the number of MEM cycles already spent without ack,
   // so the cycle in which it equals MEM_TIMEOUT-1 is the last one allowed.
   localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

   state_t      state_r;
   state_t      state_nxt;
   logic [31:0] ir_r;
   logic        cond_r;
   logic [7:0]  wait_cnt_r;
   logic        fault_r;

   // Instruction field decode from the latched IR
   logic       is_branch;
   logic       is_link;
   logic       is_dp;
   logic       is_ls;
   logic       is_load;
   logic       is_test;
   logic [3:0] rd;
   logic       wait_expired;

   assign is_branch    = (ir_r[27:25] == 3'b101);
   assign is_link      = ir_r[24];
   assign is_dp        = (ir_r[27:26] == 2'b00);
   assign is_ls        = (ir_r[27:26] == 2'b01);
   assign is_load      = ir_r[20];
   // TST/TEQ/CMP/CMN only update flags; they never write a register
   assign is_test      = is_dp && (ir_r[24:23] == 2'b10);
   assign rd           = ir_r[15:12];
   assign wait_expired = (wait_cnt_r == LAST_WAIT);

   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      logic pass;
      n = nzcv[3];
      z = nzcv[2];
      c = nzcv[1];
      v = nzcv[0];
      case (cond)
         4'h0:    pass = z;
         4'h1:    pass = !z;
         4'h2:    pass = c;
         4'h3:    pass = !c;
         4'h4:    pass = n;
         4'h5:    pass = !n;
         4'h6:    pass = v;
         4'h7:    pass = !v;
         4'h8:    pass = c && !z;
         4'h9:    pass = !c || z;
         4'hA:    pass = (n == v);
         4'hB:    pass = (n != v);
         4'hC:    pass = !z && (n == v);
         4'hD:    pass = z || (n != v);
         4'hE:    pass = 1'b1;
         default: pass = 1'b0;
      endcase
      return pass;
   endfunction

   // State register and datapath-side state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= S_FETCH;
         ir_r       <= '0;
         cond_r     <= 1'b0;
         wait_cnt_r <= '0;
         fault_r    <= 1'b0;
      end else begin
         state_r <= state_nxt;
         case (state_r)
            S_FETCH:  ir_r   <= inst_i;
            S_DECODE: cond_r <= cond_pass(ir_r[31:28], flags_i);
            S_EXEC:   wait_cnt_r <= '0;
            S_MEM: begin
               if (!mem_ack_i) begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
                  if (wait_expired) begin
                     fault_r <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and strobe decode
   always_comb begin
      state_nxt  = state_r;
      pc_we_o    = 1'b0;
      pc_sel_o   = PC_SEL_SEQ;
      reg_we_o   = 1'b0;
      reg_wa_o   = rd;
      wb_sel_o   = WB_SEL_ALU;
      flags_we_o = 1'b0;
      mem_req_o  = 1'b0;
      mem_we_o   = 1'b0;

      case (state_r)
         S_FETCH: begin
            state_nxt = S_DECODE;
         end

         S_DECODE: begin
            state_nxt = S_EXEC;
         end

         S_EXEC: begin
            if (!cond_r) begin
               pc_we_o   = 1'b1;
               state_nxt = S_FETCH;
            end else if (is_branch) begin
               pc_we_o  = 1'b1;
               pc_sel_o = PC_SEL_BRANCH;
               if (is_link) begin
                  reg_we_o = 1'b1;
                  reg_wa_o = LINK_REG;
                  wb_sel_o = WB_SEL_LINK;
               end
               state_nxt = S_FETCH;
            end else if (is_dp) begin
               flags_we_o = ir_r[20];
               state_nxt  = S_WB;
            end else if (is_ls) begin
               state_nxt = S_MEM;
            end else begin
               // Unsupported encodings retire as no-ops
               pc_we_o   = 1'b1;
               state_nxt = S_FETCH;
            end
         end

         S_MEM: begin
            mem_req_o = 1'b1;
            mem_we_o  = !is_load;
            // An ack arriving in the final allowed cycle still completes
            if (mem_ack_i) begin
               if (is_load) begin
                  state_nxt = S_WB;
               end else begin
                  pc_we_o   = 1'b1;
                  state_nxt = S_FETCH;
               end
            end else if (wait_expired) begin
               pc_we_o   = 1'b1;
               state_nxt = S_FETCH;
            end
         end

         S_WB: begin
            pc_we_o   = 1'b1;
            state_nxt = S_FETCH;
            if (!is_test) begin
               reg_we_o = 1'b1;
               wb_sel_o = is_ls ? WB_SEL_LOAD : WB_SEL_ALU;
               if (rd == PC_REG) begin
                  pc_sel_o = PC_SEL_WB;
               end
            end
         end

         default: begin
            state_nxt = S_FETCH;
         end
      endcase
   end

   assign ir_o    = ir_r;
   assign state_o = state_r;
   assign fault_o = fault_r;

endmodule
